mem_bus_arbiter: RTL

Round-robin arbiter and access sequencer that shares the computer's single 8-bit memory/IO bus among up to four requesters: CPU fetch, CPU data, DMA, and debug loader. It sits between the requesters and the memory/port bank. It grants one requester per tenure, drives the shared bus for one access at a time, and returns an acknowledge with read data. Optional locked bursts are bounded by a hold limit so no requester can starve the others.

---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and access sequencer for the shared
// 8-bit memory/IO bus. One requester is granted per tenure. Each access takes
// two cycles: ACCESS drives the bus, and DONE returns the ack and the read
// data. A locked burst keeps the grant for at most MAX_HOLD accesses.
module mem_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bus_en,
  output logic                      bus_we,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic                      busy
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra value is needed so that MAX_HOLD fits without wrapping.
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_r;
  logic [N_REQ-1:0]    grant_r;
  logic [IDX_W-1:0]    last_r;      // current or most recent winner
  logic [HOLD_W-1:0]   hold_cnt_r;  // accesses so far in this tenure

  logic [IDX_W-1:0]    rr_win_s;
  logic                any_req_s;
  logic                keep_lock_s;

  // The search starts just after 'last' and wraps. The previous winner is
  // visited last, so it wins again only when no other requester is waiting.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && r[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Turns a requester index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Arbitration decision terms, computed from the current requests and the pointer
  always_comb begin
    rr_win_s    = rr_pick(req, last_r);
    any_req_s   = |req;
    keep_lock_s = lock[last_r] && req[last_r] && (hold_cnt_r < MAX_HOLD_C);
  end

  // Sequencer FSM: IDLE -> ACCESS -> DONE, then back to ACCESS or IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      last_r     <= IDX_W'(N_REQ - 1);
      hold_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r    <= onehot(rr_win_s);
            last_r     <= rr_win_s;
            hold_cnt_r <= HOLD_W'(1);
            state_r    <= ST_ACCESS;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // req is not sampled here, so an access that has started always completes.
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (keep_lock_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            state_r    <= ST_ACCESS;
          end else if (any_req_s) begin
            grant_r    <= onehot(rr_win_s);
            last_r     <= rr_win_s;
            hold_cnt_r <= HOLD_W'(1);
            state_r    <= ST_ACCESS;
          end else begin
            grant_r    <= '0;
            hold_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          // An unreachable encoding returns the block to a safe idle state.
          grant_r    <= '0;
          hold_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus strobes are decoded from the registered state. Address and data
  // come from the granted requester only while in ACCESS.
  always_comb begin
    bus_en    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (state_r == ST_ACCESS) begin
      bus_en    = 1'b1;
      bus_we    = req_we[last_r];
      bus_addr  = req_addr[int'(last_r)*ADDR_W +: ADDR_W];
      bus_wdata = req_wdata[int'(last_r)*DATA_W +: DATA_W];
    end else begin
      bus_en    = 1'b0;
    end
  end

  // Completion: ack goes to the held grant in DONE. rdata is forced to 0
  // in every other state.
  always_comb begin
    ack   = '0;
    rdata = '0;
    if (state_r == ST_DONE) begin
      ack   = grant_r;
      rdata = bus_rdata;
    end else begin
      ack   = '0;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r != ST_IDLE);

endmodule
